// File: rtl/ci_initiator.sv
// Custom-instruction initiator: queues host commands, issues them one at a time
// to a CI responder with a WAIT timeout, and returns in-order responses.
module ci_initiator #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmdValid,
    output logic        cmdReady,
    input  logic [7:0]  cmdCiN,
    input  logic [31:0] cmdValueA,
    input  logic [31:0] cmdValueB,
    output logic        ciStart,
    output logic [7:0]  ciN,
    output logic [31:0] ciValueA,
    output logic [31:0] ciValueB,
    input  logic        ciDone,
    input  logic [31:0] ciResult,
    output logic        rspValid,
    input  logic        rspReady,
    output logic [31:0] rspResult,
    output logic        rspError,
    output logic        busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef struct packed {
        logic [7:0]  n;
        logic [31:0] a;
        logic [31:0] b;
    } cmd_t;

    cmd_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             avail_q;
    logic             push, pop;
    cmd_t             head;

    logic [1:0]  state_q, state_d;
    logic [15:0] tmo_q, tmo_d;
    logic [7:0]  ci_n_q, ci_n_d;
    logic [31:0] ci_a_q, ci_a_d;
    logic [31:0] ci_b_q, ci_b_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic        rsp_error_q, rsp_error_d;

    assign cmdReady = (count_q < CNT_W'(FIFO_DEPTH));
    assign push     = cmdValid && cmdReady;
    // avail_q is a one-cycle qualification stage that fixes push-to-start latency.
    assign pop      = (state_q == ST_IDLE) && avail_q && (count_q != '0);
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: queue storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{n: cmdCiN, a: cmdValueA, b: cmdValueB};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            avail_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            avail_q <= (count_q != '0);
        end
    end

    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d      = state_q;
        tmo_d        = tmo_q;
        ci_n_d       = ci_n_q;
        ci_a_d       = ci_a_q;
        ci_b_d       = ci_b_q;
        rsp_result_d = rsp_result_q;
        rsp_error_d  = rsp_error_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d = ST_ISSUE;
                    ci_n_d  = head.n;
                    ci_a_d  = head.a;
                    ci_b_d  = head.b;
                end
            end
            ST_ISSUE: begin
                if (ciDone) begin
                    state_d      = ST_RESP;
                    rsp_result_d = ciResult;
                    rsp_error_d  = 1'b0;
                    ci_n_d       = '0;
                    ci_a_d       = '0;
                    ci_b_d       = '0;
                end else begin
                    state_d = ST_WAIT;
                    tmo_d   = '0;
                end
            end
            ST_WAIT: begin
                // A completion in the final WAIT cycle takes priority over the timeout.
                if (ciDone || (tmo_q == TMO_LAST)) begin
                    state_d      = ST_RESP;
                    rsp_result_d = ciDone ? ciResult : 32'd0;
                    rsp_error_d  = !ciDone;
                    tmo_d        = '0;
                    ci_n_d       = '0;
                    ci_a_d       = '0;
                    ci_b_d       = '0;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            ST_RESP: begin
                if (rspReady) begin
                    state_d      = ST_IDLE;
                    rsp_result_d = '0;
                    rsp_error_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            tmo_q        <= '0;
            ci_n_q       <= '0;
            ci_a_q       <= '0;
            ci_b_q       <= '0;
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            ci_n_q       <= ci_n_d;
            ci_a_q       <= ci_a_d;
            ci_b_q       <= ci_b_d;
            rsp_result_q <= rsp_result_d;
            rsp_error_q  <= rsp_error_d;
        end
    end

    assign ciStart   = (state_q == ST_ISSUE);
    assign ciN       = ci_n_q;
    assign ciValueA  = ci_a_q;
    assign ciValueB  = ci_b_q;
    assign rspValid  = (state_q == ST_RESP);
    assign rspResult = rsp_result_q;
    assign rspError  = rsp_error_q;
    assign busy      = (count_q != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_ci_initiator.sv
// Directed self-checking bench for ci_initiator: latency, timeout, back-pressure,
// zero-latency responder and mid-operation reset.
module tb_ci_initiator;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmdValid;
    logic        cmdReady;
    logic [7:0]  cmdCiN;
    logic [31:0] cmdValueA, cmdValueB;
    logic        ciStart;
    logic [7:0]  ciN;
    logic [31:0] ciValueA, ciValueB;
    logic        ciDone;
    logic [31:0] ciResult;
    logic        rspValid, rspReady;
    logic [31:0] rspResult;
    logic        rspError;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int n_start  = 0;
    int since_start = 0;
    logic [7:0]  last_n = '0;
    logic [31:0] last_a = '0;
    int s0;

    ci_initiator #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(255)) dut (
        .clock(clock), .reset(reset),
        .cmdValid(cmdValid), .cmdReady(cmdReady),
        .cmdCiN(cmdCiN), .cmdValueA(cmdValueA), .cmdValueB(cmdValueB),
        .ciStart(ciStart), .ciN(ciN), .ciValueA(ciValueA), .ciValueB(ciValueB),
        .ciDone(ciDone), .ciResult(ciResult),
        .rspValid(rspValid), .rspReady(rspReady),
        .rspResult(rspResult), .rspError(rspError),
        .busy(busy)
    );

    always #5 clock = ~clock;

    // Observer: counts start pulses, cycles since the last start, and the issued payload.
    always @(negedge clock) begin
        if (ciStart) begin
            n_start     <= n_start + 1;
            since_start <= 0;
            last_n      <= ciN;
            last_a      <= ciValueA;
        end else begin
            since_start <= since_start + 1;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input string tag);
        for (int k = 0; k < 20 && !ciStart; k++) tick();
        check(tag, ciStart, 1'b1);
    endtask

    task automatic wait_rsp(input string tag);
        for (int k = 0; k < 400 && !rspValid; k++) tick();
        check(tag, rspValid, 1'b1);
    endtask

    task automatic push(input logic [7:0] n, input logic [31:0] a, input logic [31:0] b);
        cmdValid  = 1'b1;
        cmdCiN    = n;
        cmdValueA = a;
        cmdValueB = b;
        tick();
        cmdValid  = 1'b0;
    endtask

    initial begin
        reset = 1'b0; cmdValid = 1'b0; cmdCiN = '0; cmdValueA = '0; cmdValueB = '0;
        ciDone = 1'b0; ciResult = '0; rspReady = 1'b0;

        // Reset values
        #2;
        check("rst_ciStart", ciStart, 1'b0);
        check("rst_ciN", ciN, 8'h00);
        check("rst_ciValueA", ciValueA, 32'h0);
        check("rst_ciValueB", ciValueB, 32'h0);
        check("rst_rspValid", rspValid, 1'b0);
        check("rst_rspResult", rspResult, 32'h0);
        check("rst_rspError", rspError, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        check("rst_cmdReady", cmdReady, 1'b1);
        tick();

        // Single command, responder completes 3 cycles after ciStart
        s0 = n_start;
        push(8'h0D, 32'h202, 32'hFE);
        check("lat_e0_start", ciStart, 1'b0);
        check("lat_e0_busy", busy, 1'b1);
        tick();
        check("lat_e1_start", ciStart, 1'b0);
        tick();
        check("lat_e2_start", ciStart, 1'b1);
        check("issue_ciN", ciN, 8'h0D);
        check("issue_ciValueA", ciValueA, 32'h202);
        check("issue_ciValueB", ciValueB, 32'hFE);
        tick();
        check("start_one_cycle", ciStart, 1'b0);
        check("wait_ciN_stable", ciN, 8'h0D);
        check("wait_ciValueA_stable", ciValueA, 32'h202);
        tick();
        tick();
        ciDone = 1'b1; ciResult = 32'h1234_5678;
        tick();
        ciDone = 1'b0;
        check("single_rspValid", rspValid, 1'b1);
        check("single_rspResult", rspResult, 32'h1234_5678);
        check("single_rspError", rspError, 1'b0);
        check("resp_ciN_zero", ciN, 8'h00);
        rspReady = 1'b1;
        tick();
        check("single_done_rspValid", rspValid, 1'b0);
        check("single_done_busy", busy, 1'b0);
        check("single_start_count", 32'(n_start - s0), 32'd1);

        // Zero-latency responder
        push(8'h30, 32'h1, 32'h2);
        tick();
        tick();
        check("zl_start", ciStart, 1'b1);
        ciDone = 1'b1; ciResult = 32'hFE;
        tick();
        ciDone = 1'b0;
        check("zl_rspValid", rspValid, 1'b1);
        check("zl_rspResult", rspResult, 32'hFE);
        check("zl_rspError", rspError, 1'b0);
        check("zl_no_wait", 32'(since_start), 32'd0);
        tick();
        check("zl_done_rspValid", rspValid, 1'b0);

        // Back-pressure: response held 10 cycles with 2 commands queued
        rspReady = 1'b0;
        cmdValid = 1'b1;
        cmdCiN = 8'h11; cmdValueA = 32'h100; cmdValueB = 32'h200; tick();
        cmdCiN = 8'h12; cmdValueA = 32'h101; tick();
        cmdCiN = 8'h13; cmdValueA = 32'h102; tick();
        cmdValid = 1'b0;
        check("bp_start1", ciStart, 1'b1);
        check("bp_ciN1", ciN, 8'h11);
        ciDone = 1'b1; ciResult = 32'hA1;
        tick();
        ciResult = 32'hBAD;
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_rspValid", rspValid, 1'b1);
            check("bp_hold_rspResult", rspResult, 32'hA1);
            check("bp_hold_no_start", ciStart, 1'b0);
            tick();
        end
        ciDone = 1'b0;
        rspReady = 1'b1;
        tick();
        check("bp_release_rspValid", rspValid, 1'b0);
        tick();
        check("bp_start2", ciStart, 1'b1);
        check("bp_ciN2", ciN, 8'h12);
        check("bp_ciValueA2", ciValueA, 32'h101);
        ciDone = 1'b1; ciResult = 32'hA2;
        tick();
        ciDone = 1'b0;
        check("bp_rspResult2", rspResult, 32'hA2);
        tick();
        tick();
        check("bp_ciN3", ciN, 8'h13);
        ciDone = 1'b1; ciResult = 32'hA3;
        tick();
        ciDone = 1'b0;
        check("bp_rspResult3", rspResult, 32'hA3);
        tick();
        check("bp_idle_busy", busy, 1'b0);

        // Five back-to-back commands, silent responder, all time out in order
        for (int i = 0; i < 5; i++) begin
            check("fill_cmdReady", cmdReady, 1'b1);
            cmdValid = 1'b1; cmdCiN = 8'(8'h40 + i); cmdValueA = 32'(i); cmdValueB = '0;
            tick();
        end
        cmdValid = 1'b0;
        check("full_cmdReady", cmdReady, 1'b0);
        for (int i = 0; i < 5; i++) begin
            wait_rsp("tmo_rsp_arrives");
            check("tmo_rspResult", rspResult, 32'h0);
            check("tmo_rspError", rspError, 1'b1);
            check("tmo_wait_cycles", 32'(since_start), 32'd255);
            check("tmo_order_ciN", last_n, 8'(8'h40 + i));
            check("tmo_order_ciValueA", last_a, 32'(i));
            tick();
        end
        check("tmo_idle_busy", busy, 1'b0);

        // ciDone coincides with the final timeout cycle
        push(8'h55, 32'h5, 32'h6);
        wait_start("edge_start");
        repeat (255) tick();
        check("edge_still_waiting", rspValid, 1'b0);
        ciDone = 1'b1; ciResult = 32'h22;
        tick();
        ciDone = 1'b0;
        check("edge_rspValid", rspValid, 1'b1);
        check("edge_rspResult", rspResult, 32'h22);
        check("edge_rspError", rspError, 1'b0);
        tick();

        // Reset in WAIT with 3 commands queued
        rspReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmdValid = 1'b1; cmdCiN = 8'(8'h60 + i); cmdValueA = 32'(i + 16); cmdValueB = 32'h0;
            tick();
        end
        cmdValid = 1'b0;
        check("mid_in_wait_ciN", ciN, 8'h60);
        check("mid_in_wait_start", ciStart, 1'b0);
        check("mid_busy", busy, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_ciStart", ciStart, 1'b0);
        check("arst_ciN", ciN, 8'h00);
        check("arst_ciValueA", ciValueA, 32'h0);
        check("arst_ciValueB", ciValueB, 32'h0);
        check("arst_rspValid", rspValid, 1'b0);
        check("arst_rspResult", rspResult, 32'h0);
        check("arst_rspError", rspError, 1'b0);
        check("arst_busy", busy, 1'b0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("arst_release_cmdReady", cmdReady, 1'b1);
        check("arst_release_busy", busy, 1'b0);
        s0 = n_start;
        repeat (10) tick();
        check("arst_no_start", 32'(n_start - s0), 32'd0);
        check("arst_quiet_busy", busy, 1'b0);

        // Fresh command after reset still works
        rspReady = 1'b1;
        push(8'h77, 32'h7, 32'h8);
        tick();
        tick();
        check("post_rst_start", ciStart, 1'b1);
        check("post_rst_ciN", ciN, 8'h77);
        ciDone = 1'b1; ciResult = 32'h99;
        tick();
        ciDone = 1'b0;
        check("post_rst_rspResult", rspResult, 32'h99);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
